// File: rtl/cic_interpolator.sv
// CIC interpolator: M comb stages at the input rate, zero-stuffing by R, M integrators at the output rate.
// Optional sticky underrun flag enabled by defining CIC_INTERP_UNDERRUN_EN.
module cic_interpolator #(
    parameter int IW = 10,
    parameter int R  = 10,
    parameter int M  = 3,
    parameter int OW = 22
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ce,
    input  logic                 i_valid,
    input  logic signed [IW-1:0] i_data,
    output logic                 o_in_ready,
    output logic signed [OW-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_underrun
);
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam int WI = IW + M * $clog2(R);

    logic [PW-1:0]        phase_q, phase_d;
    logic                 strobe;
    logic signed [WI-1:0] c     [M+1];
    logic signed [WI-1:0] d_q   [M];
    logic signed [WI-1:0] u_q, u_d;
    logic signed [WI-1:0] y_q   [M];
    logic signed [WI-1:0] y_d   [M];
    logic                 valid_q;

    assign strobe     = i_ce & (phase_q == '0);
    assign o_in_ready = (phase_q == '0);
    assign phase_d    = (phase_q == PW'(R - 1)) ? '0 : phase_q + 1'b1;

    // Comb chain is combinational; a missing sample on the strobe enters as zero.
    always_comb begin
        c[0] = i_valid ? {{(WI-IW){i_data[IW-1]}}, i_data} : '0;
        for (int unsigned k = 0; k < M; k++) begin
            c[k+1] = c[k] - d_q[k];
        end
        u_d = strobe ? c[M] : '0;
    end

    always_comb begin
        y_d[0] = y_q[0] + u_q;
        for (int unsigned k = 1; k < M; k++) begin
            y_d[k] = y_q[k] + y_q[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            phase_q <= '0;
            u_q     <= '0;
            valid_q <= 1'b0;
            for (int unsigned k = 0; k < M; k++) begin
                d_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            valid_q <= i_ce;
            if (i_ce) begin
                phase_q <= phase_d;
                u_q     <= u_d;
                for (int unsigned k = 0; k < M; k++) begin
                    if (strobe) begin
                        d_q[k] <= c[k];
                    end
                    y_q[k] <= y_d[k];
                end
            end
        end
    end

    assign o_data  = y_q[M-1][WI-1 -: OW];
    assign o_valid = valid_q;

`ifdef CIC_INTERP_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            underrun_q <= 1'b0;
        end else if (strobe && !i_valid) begin
            underrun_q <= 1'b1;
        end
    end

    assign o_underrun = underrun_q;
`else
    assign o_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: three instances cover the hold, impulse and DC-gain configurations.
module tb_cic_interpolator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // A: IW=8 R=4 M=1 (WI=10)
    logic a_rst_n, a_ce, a_valid, a_ready, a_ov, a_ur;
    logic signed [7:0] a_data;
    logic signed [9:0] a_out;
    // B: IW=8 R=2 M=2 (WI=10)
    logic b_rst_n, b_ce, b_valid, b_ready, b_ov, b_ur;
    logic signed [7:0] b_data;
    logic signed [9:0] b_out;
    // C: IW=10 R=10 M=3 (WI=22)
    logic c_rst_n, c_ce, c_valid, c_ready, c_ov, c_ur;
    logic signed [9:0]  c_data;
    logic signed [21:0] c_out;

    cic_interpolator #(.IW(8), .R(4), .M(1), .OW(10)) u_a (
        .i_clk(clk), .i_reset_n(a_rst_n), .i_ce(a_ce), .i_valid(a_valid), .i_data(a_data),
        .o_in_ready(a_ready), .o_data(a_out), .o_valid(a_ov), .o_underrun(a_ur));
    cic_interpolator #(.IW(8), .R(2), .M(2), .OW(10)) u_b (
        .i_clk(clk), .i_reset_n(b_rst_n), .i_ce(b_ce), .i_valid(b_valid), .i_data(b_data),
        .o_in_ready(b_ready), .o_data(b_out), .o_valid(b_ov), .o_underrun(b_ur));
    cic_interpolator #(.IW(10), .R(10), .M(3), .OW(22)) u_c (
        .i_clk(clk), .i_reset_n(c_rst_n), .i_ce(c_ce), .i_valid(c_valid), .i_data(c_data),
        .o_in_ready(c_ready), .o_data(c_out), .o_valid(c_ov), .o_underrun(c_ur));

    int hold_exp [8] = '{0, 5, 5, 5, 5, 0, 0, 0};
    int imp_exp  [7] = '{0, 0, 1, 2, 1, 0, 0};

`ifdef CIC_INTERP_UNDERRUN_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst_n = 1'b0;
        step();
        a_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a_rst_n = 0; b_rst_n = 0; c_rst_n = 0;
        a_ce = 1; b_ce = 1; c_ce = 1;
        a_valid = 1; b_valid = 1; c_valid = 1;
        a_data = 8'sd7; b_data = 8'sd7; c_data = 10'sd7;
        step(); step();
        a_rst_n = 1; b_rst_n = 1; c_rst_n = 1;
        a_ce = 0; b_ce = 0; c_ce = 0;
        tests++; if (a_out !== 10'sd0 || b_out !== 10'sd0 || c_out !== 22'sd0) begin
            fails++; $display("FAIL reset_data a=%0d b=%0d c=%0d required 0", a_out, b_out, c_out); end
        tests++; if (a_ov !== 1'b0 || b_ov !== 1'b0 || c_ov !== 1'b0) begin
            fails++; $display("FAIL reset_valid a=%b b=%b c=%b required 0", a_ov, b_ov, c_ov); end
        tests++; if (a_ready !== 1'b1 || b_ready !== 1'b1 || c_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready a=%b b=%b c=%b required 1", a_ready, b_ready, c_ready); end
        tests++; if (a_ur !== 1'b0 || b_ur !== 1'b0 || c_ur !== 1'b0) begin
            fails++; $display("FAIL reset_underrun a=%b b=%b c=%b required 0", a_ur, b_ur, c_ur); end
        // released with i_ce low: nothing moves and o_valid stays low
        a_data = 8'sd9; a_valid = 1;
        step(); step();
        tests++; if (a_ov !== 1'b0 || a_ready !== 1'b1 || a_out !== 10'sd0) begin
            fails++; $display("FAIL idle_ce0 valid=%b ready=%b data=%0d required 0/1/0", a_ov, a_ready, a_out); end
    endtask

    task automatic test_hold();
        a_ce = 1; a_valid = 1;
        for (int k = 1; k <= 8; k++) begin
            a_data = (k == 1) ? 8'sd5 : 8'sd0;
            step();
            tests++; if (a_out !== 10'(hold_exp[k-1])) begin
                fails++; $display("FAIL hold_data[%0d] got %0d required %0d", k, a_out, hold_exp[k-1]); end
            tests++; if (a_ready !== (k % 4 == 0) || a_ov !== 1'b1) begin
                fails++; $display("FAIL hold_ctl[%0d] ready=%b valid=%b required %b/1", k, a_ready, a_ov, (k % 4 == 0)); end
        end
    endtask

    task automatic test_enable_gaps();
        logic signed [9:0] prev;
        reset_a();
        a_valid = 1;
        for (int k = 1; k <= 8; k++) begin
            a_ce = 1;
            a_data = (k == 1) ? 8'sd5 : 8'sd0;
            step();
            tests++; if (a_out !== 10'(hold_exp[k-1]) || a_ov !== 1'b1) begin
                fails++; $display("FAIL gap_data[%0d] got %0d/%b required %0d/1", k, a_out, a_ov, hold_exp[k-1]); end
            prev = a_out;
            a_ce = 0;
            a_data = 8'sd33;
            for (int g = 0; g < 2; g++) begin
                step();
                tests++; if (a_ov !== 1'b0 || a_out !== prev || a_ready !== (k % 4 == 0)) begin
                    fails++; $display("FAIL gap_hold[%0d.%0d] valid=%b data=%0d ready=%b required 0/%0d/%b",
                                      k, g, a_ov, a_out, a_ready, prev, (k % 4 == 0)); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        reset_a();
        a_ce = 1; a_valid = 1;
        for (int k = 1; k <= 3; k++) begin
            a_data = (k == 1) ? 8'sd5 : 8'sd0;
            step();
        end
        tests++; if (a_out !== 10'sd5) begin
            fails++; $display("FAIL mid_pre got %0d required 5", a_out); end
        a_rst_n = 0;
        step();
        a_rst_n = 1;
        tests++; if (a_out !== 10'sd0 || a_ov !== 1'b0 || a_ready !== 1'b1 || a_ur !== 1'b0) begin
            fails++; $display("FAIL mid_reset data=%0d valid=%b ready=%b ur=%b required 0/0/1/0", a_out, a_ov, a_ready, a_ur); end
        for (int k = 1; k <= 8; k++) begin
            a_data = (k == 1) ? 8'sd5 : 8'sd0;
            step();
            tests++; if (a_out !== 10'(hold_exp[k-1]) || a_ready !== (k % 4 == 0)) begin
                fails++; $display("FAIL mid_replay[%0d] got %0d/%b required %0d/%b", k, a_out, a_ready, hold_exp[k-1], (k % 4 == 0)); end
        end
    endtask

    task automatic test_underrun();
        reset_a();
        a_ce = 1;
        for (int k = 1; k <= 8; k++) begin
            a_valid = (k != 5);
            a_data  = (k == 1) ? 8'sd5 : 8'sd0;
            step();
            tests++; if (a_out !== 10'(hold_exp[k-1]) || a_ready !== (k % 4 == 0)) begin
                fails++; $display("FAIL underrun_data[%0d] got %0d/%b required %0d/%b", k, a_out, a_ready, hold_exp[k-1], (k % 4 == 0)); end
            tests++; if (a_ur !== (UR_EN && k >= 5)) begin
                fails++; $display("FAIL underrun_flag[%0d] got %b required %b", k, a_ur, (UR_EN && k >= 5)); end
        end
        a_valid = 1;
    endtask

    task automatic test_impulse();
        b_ce = 1; b_valid = 1;
        for (int k = 1; k <= 7; k++) begin
            b_data = (k == 1) ? 8'sd1 : 8'sd0;
            step();
            tests++; if (b_out !== 10'(imp_exp[k-1]) || b_ready !== (k % 2 == 0)) begin
                fails++; $display("FAIL impulse[%0d] got %0d/%b required %0d/%b", k, b_out, b_ready, imp_exp[k-1], (k % 2 == 0)); end
        end
    endtask

    task automatic test_dc_gain();
        c_ce = 1; c_valid = 1; c_data = 10'sd1;
        for (int k = 0; k < 60; k++) step();
        for (int k = 0; k < 10; k++) begin
            tests++; if (c_out !== 22'sd100) begin
                fails++; $display("FAIL dc_pos[%0d] got %0d required 100", k, c_out); end
            step();
        end
        c_data = -10'sd1;
        for (int k = 0; k < 60; k++) step();
        for (int k = 0; k < 10; k++) begin
            tests++; if (c_out !== -22'sd100) begin
                fails++; $display("FAIL dc_neg[%0d] got %0d required -100", k, c_out); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_enable_gaps();
        test_reset_midstream();
        test_underrun();
        test_impulse();
        test_dc_gain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
